// File: rtl/campo_editor.sv
// Field editor for the clock overlay: passes live RTC/timer BCD through, or lets
// the user step through 9 fields and adjust them, committing with a load strobe.
module campo_editor #(
  parameter int TIMEOUT_CYC = 500000000,
  parameter int TO_W        = 29
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_edit,
  input  logic [23:0] live_fecha,
  input  logic [23:0] live_hora,
  input  logic [23:0] live_timer,
  output logic [23:0] out_fecha,
  output logic [23:0] out_hora,
  output logic [23:0] out_timer,
  output logic [3:0]  dir,
  output logic        cursor,
  output logic        load_o,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EDIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state;
  logic [4:0]      btn_prev;
  logic [4:0]      btn_cur;
  logic [4:0]      rise;
  logic [TO_W-1:0] to_cnt;

  logic act_edit, act_right, act_left, act_up, act_down, any_act;

  logic [3:0]  dir_eff;
  logic [7:0]  fld_val;
  logic [7:0]  fld_min;
  logic [7:0]  fld_max;
  logic [7:0]  fld_new;
  logic [23:0] nxt_fecha;
  logic [23:0] nxt_hora;
  logic [23:0] nxt_timer;

  assign state_dbg = state;

  // Bit order doubles as priority order: edit wins over everything below it.
  assign btn_cur   = {btn_edit, btn_right, btn_left, btn_up, btn_down};
  assign rise      = btn_cur & ~btn_prev;
  assign act_edit  = rise[4];
  assign act_right = rise[3] & ~rise[4];
  assign act_left  = rise[2] & ~(|rise[4:3]);
  assign act_up    = rise[1] & ~(|rise[4:2]);
  assign act_down  = rise[0] & ~(|rise[4:1]);
  assign any_act   = |rise;

  assign dir_eff = (dir > 4'd8) ? 4'd0 : dir;

  // One BCD step of a two-digit field; any malformed or out-of-range value snaps to min.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi, input logic up);
    logic [3:0] t;
    logic [3:0] u;
    logic       ok;
    logic [7:0] r;
    t  = v[7:4];
    u  = v[3:0];
    ok = (t <= 4'd9) && (u <= 4'd9) && (v >= lo) && (v <= hi);
    if (!ok) begin
      r = lo;
    end else if (up) begin
      if (v == hi)        r = lo;
      else if (u == 4'd9) r = {t + 4'd1, 4'd0};
      else                r = {t, u + 4'd1};
    end else begin
      if (v == lo)        r = hi;
      else if (u == 4'd0) r = {t - 4'd1, 4'd9};
      else                r = {t, u - 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    fld_val = out_fecha[23:16];
    fld_min = 8'h01;
    fld_max = 8'h31;
    case (dir_eff)
      4'd1: begin fld_val = out_fecha[15:8];  fld_min = 8'h01; fld_max = 8'h12; end
      4'd2: begin fld_val = out_fecha[7:0];   fld_min = 8'h00; fld_max = 8'h99; end
      4'd3: begin fld_val = out_hora[23:16];  fld_min = 8'h00; fld_max = 8'h23; end
      4'd4: begin fld_val = out_hora[15:8];   fld_min = 8'h00; fld_max = 8'h59; end
      4'd5: begin fld_val = out_hora[7:0];    fld_min = 8'h00; fld_max = 8'h59; end
      4'd6: begin fld_val = out_timer[23:16]; fld_min = 8'h00; fld_max = 8'h23; end
      4'd7: begin fld_val = out_timer[15:8];  fld_min = 8'h00; fld_max = 8'h59; end
      4'd8: begin fld_val = out_timer[7:0];   fld_min = 8'h00; fld_max = 8'h59; end
      default: begin fld_val = out_fecha[23:16]; fld_min = 8'h01; fld_max = 8'h31; end
    endcase
  end

  assign fld_new = bcd_step(fld_val, fld_min, fld_max, act_up);

  always_comb begin
    nxt_fecha = out_fecha;
    nxt_hora  = out_hora;
    nxt_timer = out_timer;
    case (dir_eff)
      4'd1:    nxt_fecha[15:8]  = fld_new;
      4'd2:    nxt_fecha[7:0]   = fld_new;
      4'd3:    nxt_hora[23:16]  = fld_new;
      4'd4:    nxt_hora[15:8]   = fld_new;
      4'd5:    nxt_hora[7:0]    = fld_new;
      4'd6:    nxt_timer[23:16] = fld_new;
      4'd7:    nxt_timer[15:8]  = fld_new;
      4'd8:    nxt_timer[7:0]   = fld_new;
      default: nxt_fecha[23:16] = fld_new;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state     <= S_IDLE;
      btn_prev  <= '0;
      to_cnt    <= '0;
      dir       <= 4'd0;
      cursor    <= 1'b0;
      load_o    <= 1'b0;
      out_fecha <= '0;
      out_hora  <= '0;
      out_timer <= '0;
    end else begin
      btn_prev <= btn_cur;
      load_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          out_fecha <= live_fecha;
          out_hora  <= live_hora;
          out_timer <= live_timer;
          cursor    <= 1'b0;
          if (act_edit) begin
            state  <= S_EDIT;
            cursor <= 1'b1;
            dir    <= 4'd0;
            to_cnt <= '0;
          end
        end
        S_EDIT: begin
          if (any_act) begin
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            state  <= S_IDLE;
            cursor <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
          if (act_edit) begin
            state  <= S_COMMIT;
            load_o <= 1'b1;
            cursor <= 1'b0;
          end else if (act_right) begin
            dir <= (dir_eff == 4'd8) ? 4'd0 : dir_eff + 4'd1;
          end else if (act_left) begin
            dir <= (dir_eff == 4'd0) ? 4'd8 : dir_eff - 4'd1;
          end else if (act_up || act_down) begin
            out_fecha <= nxt_fecha;
            out_hora  <= nxt_hora;
            out_timer <= nxt_timer;
          end
        end
        S_COMMIT: begin
          state  <= S_IDLE;
          cursor <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          cursor <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_campo_editor.sv
// Bench for campo_editor: directed walkthrough followed by random button/live traffic,
// all checked against a decimal-arithmetic model of the editor.
module tb_campo_editor;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  btns = 5'd0;   // {edit, right, left, up, down}
  logic [23:0] live_fecha = '0;
  logic [23:0] live_hora  = '0;
  logic [23:0] live_timer = '0;
  logic [23:0] out_fecha, out_hora, out_timer;
  logic [3:0]  dir;
  logic        cursor, load_o;
  logic [1:0]  state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: mode 0 = idle, 1 = editing, 2 = commit cycle.
  int         m_mode = 0;
  int         m_dir  = 0;
  int         m_cnt  = 0;
  logic [4:0] m_prev = '0;
  logic [7:0] m_f[9];
  logic [71:0] exp_q[$];

  campo_editor #(.TIMEOUT_CYC(TO), .TO_W(5)) dut (
    .clk_i(clk), .reset(reset),
    .btn_up(btns[1]), .btn_down(btns[0]), .btn_left(btns[2]),
    .btn_right(btns[3]), .btn_edit(btns[4]),
    .live_fecha(live_fecha), .live_hora(live_hora), .live_timer(live_timer),
    .out_fecha(out_fecha), .out_hora(out_hora), .out_timer(out_timer),
    .dir(dir), .cursor(cursor), .load_o(load_o), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int fmax(input int k);
    case (k)
      0: return 31;
      1: return 12;
      2: return 99;
      3, 6: return 23;
      default: return 59;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic [7:0] adjust(input int k, input logic [7:0] b, input bit up);
    int lo, hi, t, u, v;
    lo = (k < 2) ? 1 : 0;
    hi = fmax(k);
    t  = int'(b[7:4]);
    u  = int'(b[3:0]);
    v  = t * 10 + u;
    if (t > 9 || u > 9 || v < lo || v > hi) return to_bcd(lo);
    if (up) v = (v == hi) ? lo : v + 1;
    else    v = (v == lo) ? hi : v - 1;
    return to_bcd(v);
  endfunction

  function automatic logic [23:0] m_bus(input int g);
    return {m_f[3*g], m_f[3*g+1], m_f[3*g+2]};
  endfunction

  task automatic load_live();
    {m_f[0], m_f[1], m_f[2]} = live_fecha;
    {m_f[3], m_f[4], m_f[5]} = live_hora;
    {m_f[6], m_f[7], m_f[8]} = live_timer;
  endtask

  task automatic model_step();
    logic [4:0] rise;
    int act;
    if (reset) begin
      m_mode = 0; m_dir = 0; m_cnt = 0; m_prev = '0;
      for (int k = 0; k < 9; k++) m_f[k] = 8'h00;
      return;
    end
    rise   = btns & ~m_prev;
    m_prev = btns;
    act = 0;
    for (int b = 4; b >= 0; b--) if (act == 0 && rise[b]) act = 5 - b;  // 1=edit..5=down
    case (m_mode)
      0: begin
        load_live();
        if (act == 1) begin m_mode = 1; m_dir = 0; m_cnt = 0; end
      end
      1: begin
        if (act == 0) begin
          if (m_cnt == TO - 1) m_mode = 0;
          else m_cnt++;
        end else begin
          m_cnt = 0;
          case (act)
            1: m_mode = 2;
            2: m_dir = (m_dir + 1) % 9;
            3: m_dir = (m_dir + 8) % 9;
            4: m_f[m_dir] = adjust(m_dir, m_f[m_dir], 1'b1);
            default: m_f[m_dir] = adjust(m_dir, m_f[m_dir], 1'b0);
          endcase
        end
      end
      default: m_mode = 0;
    endcase
    if (m_mode == 2) exp_q.push_back({m_bus(0), m_bus(1), m_bus(2)});
  endtask

  task automatic tick();
    logic [71:0] e;
    model_step();
    @(posedge clk);
    #1;
    check("out_fecha", out_fecha, m_bus(0));
    check("out_hora", out_hora, m_bus(1));
    check("out_timer", out_timer, m_bus(2));
    check("dir", 24'(dir), 24'(m_dir));
    check("cursor", 24'(cursor), 24'(m_mode == 1));
    check("load_o", 24'(load_o), 24'(m_mode == 2));
    if (load_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_load", 24'(load_o), 24'd0);
      end else begin
        e = exp_q.pop_front();
        check("commit_fecha", out_fecha, e[71:48]);
        check("commit_hora", out_hora, e[47:24]);
        check("commit_timer", out_timer, e[23:0]);
      end
    end
  endtask

  task automatic press(input int b);
    btns[b] = 1'b1;
    tick();
    btns[b] = 1'b0;
    tick();
  endtask

  initial begin
    // Reset and passthrough
    reset = 1'b1;
    tick(); tick();
    check("rst_out_hora", out_hora, 24'h0);
    check("rst_dir", 24'(dir), 24'd0);
    check("rst_cursor", 24'(cursor), 24'd0);
    reset = 1'b0;
    live_hora = 24'h235958;
    tick();
    check("pass_hora", out_hora, 24'h235958);
    tick(); tick();

    // Hour 23 up -> 00, minute 00 down -> 59, commit
    live_hora = 24'h230058;
    tick();
    press(4);
    check("edit_cursor", 24'(cursor), 24'd1);
    press(3); press(3); press(3);
    check("dir3", 24'(dir), 24'd3);
    press(1);
    check("hour_wrap", out_hora, 24'h000058);
    press(3);
    press(0);
    check("min_wrap", out_hora, 24'h005958);
    btns[4] = 1'b1;
    tick();
    check("commit_load", 24'(load_o), 24'd1);
    check("commit_hora_val", out_hora, 24'h005958);
    btns[4] = 1'b0;
    tick();
    check("after_commit_load", 24'(load_o), 24'd0);
    check("after_commit_cursor", 24'(cursor), 24'd0);
    tick();
    check("resume_live", out_hora, 24'h230058);

    // Day / month / year wraps, dir wrap, held button, simultaneous up+down
    live_fecha = 24'h311209;
    tick();
    press(4);
    press(1); check("day_up", 24'(out_fecha[23:16]), 24'h01);
    press(0); check("day_down", 24'(out_fecha[23:16]), 24'h31);
    press(3); press(1); check("month_up", 24'(out_fecha[15:8]), 24'h01);
    press(3); press(1); check("year_up", 24'(out_fecha[7:0]), 24'h10);
    press(2); press(2); press(2);
    check("dir_left_wrap", 24'(dir), 24'd8);
    press(3);
    check("dir_right_wrap", 24'(dir), 24'd0);
    btns[3] = 1'b1;
    repeat (12) tick();
    btns[3] = 1'b0;
    tick();
    check("held_right", 24'(dir), 24'd1);
    btns[1:0] = 2'b11;
    tick();
    btns[1:0] = 2'b00;
    tick();
    check("up_over_down", 24'(out_fecha[15:8]), 24'h02);
    press(4);
    tick();

    live_fecha = 24'h010100;
    tick();
    press(4); press(3); press(3); press(0);
    check("year_down", 24'(out_fecha[7:0]), 24'h99);
    press(4);
    tick();

    // Inactivity timeout, then timeout restarted by an action
    live_timer = 24'h123456;
    btns[4] = 1'b1;
    tick();
    btns[4] = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      check("to_still_edit", 24'(cursor), 24'd1);
    end
    tick();
    check("to_exit", 24'(cursor), 24'd0);
    check("to_no_load", 24'(load_o), 24'd0);
    live_timer = 24'h000111;
    tick(); tick();
    check("to_resume_live", out_timer, 24'h000111);
    btns[4] = 1'b1;
    tick();
    btns[4] = 1'b0;
    repeat (9) tick();
    btns[3] = 1'b1;
    tick();
    btns[3] = 1'b0;
    for (int i = 1; i < TO; i++) tick();
    check("to_restart_hold", 24'(cursor), 24'd1);
    tick();
    check("to_restart_exit", 24'(cursor), 24'd0);

    // Reset in the middle of an edit
    press(4); press(3); press(1);
    reset = 1'b1;
    tick();
    check("mid_rst_cursor", 24'(cursor), 24'd0);
    check("mid_rst_dir", 24'(dir), 24'd0);
    check("mid_rst_hora", out_hora, 24'h0);
    check("mid_rst_load", 24'(load_o), 24'd0);
    reset = 1'b0;
    exp_q.delete();
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++) btns[b] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          live_fecha = 24'($urandom);
          live_hora  = 24'($urandom);
          live_timer = 24'($urandom);
        end else begin
          live_fecha = {to_bcd($urandom_range(1, 31)), to_bcd($urandom_range(1, 12)), to_bcd($urandom_range(0, 99))};
          live_hora  = {to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)), to_bcd($urandom_range(0, 59))};
          live_timer = {to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)), to_bcd($urandom_range(0, 59))};
        end
      end
      reset = ($urandom_range(0, 499) == 0);
      if (reset) exp_q.delete();
      tick();
    end
    reset = 1'b0;
    btns = '0;
    tick(); tick();
    check("commit_queue_empty", 24'(exp_q.size()), 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
